// File: rtl/logic_slice_sequencer_pkg.sv
// Shared definitions for the sliced bitwise logic sequencer:
// operation encodings (same as the ALU decode) and FSM state type.
package logic_slice_sequencer_pkg;

  typedef logic [1:0] lop_t;

  localparam lop_t LOP_NOR = 2'b00;
  localparam lop_t LOP_AND = 2'b01;
  localparam lop_t LOP_OR  = 2'b10;
  localparam lop_t LOP_XOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } seq_state_e;

  // Width of a counter that indexes 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/logic_slice_sequencer_slice.sv
// One narrow combinational logic slice: NOR/AND/OR/XOR of two SLICE-bit
// operands, each function built from per-bit gates, then selected by op.
module logic_slice
  import logic_slice_sequencer_pkg::*;
#(
  parameter int SLICE = 8
) (
  output logic [SLICE-1:0] Out,
  input  logic [SLICE-1:0] A,
  input  logic [SLICE-1:0] B,
  input  logic [1:0]       op
);

  logic [SLICE-1:0] nor_o;
  logic [SLICE-1:0] and_o;
  logic [SLICE-1:0] or_o;
  logic [SLICE-1:0] xor_o;

  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    nor u_nor (nor_o[i], A[i], B[i]);
    and u_and (and_o[i], A[i], B[i]);
    or  u_or  (or_o[i],  A[i], B[i]);
    xor u_xor (xor_o[i], A[i], B[i]);
  end

  // Select the requested function for this slice.
  always_comb begin
    Out = nor_o;
    case (op)
      LOP_NOR: Out = nor_o;
      LOP_AND: Out = and_o;
      LOP_OR:  Out = or_o;
      LOP_XOR: Out = xor_o;
      default: Out = nor_o;
    endcase
  end

endmodule

// File: rtl/logic_slice_sequencer.sv
// Multi-cycle 32-bit bitwise logic unit: one SLICE-wide slice evaluated per
// clock, LSB slice first, with start/ready/done handshake and flush abort.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; Out holds the last result (or 0)
//   RUN     | one slice per edge, beat selects slice; Out is partial
//   DONE    | single cycle, done=1, Out valid; start here is accepted
module logic_slice_sequencer
  import logic_slice_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Out
);

  localparam int BEATS = WIDTH / SLICE;
  localparam int BW    = idx_width(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  seq_state_e       state;
  logic [BW-1:0]    beat;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [SLICE-1:0] slice_res;

  logic_slice #(.SLICE(SLICE)) u_slice (
    .Out (slice_res),
    .A   (a_q[beat*SLICE +: SLICE]),
    .B   (b_q[beat*SLICE +: SLICE]),
    .op  (op_q)
  );

  // Sequencer FSM with registered handshake outputs, beat counter and result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      beat  <= '0;
      Out   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      ready <= 1'b1;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= LOP_NOR;
    end else if (flush) begin
      // Abort kills the operation outright; captured operands are don't-care.
      state <= ST_IDLE;
      beat  <= '0;
      Out   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      ready <= 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            op_q  <= op;
            beat  <= '0;
            Out   <= '0;
            state <= ST_RUN;
            busy  <= 1'b1;
            ready <= 1'b0;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            ready <= 1'b1;
          end
        end
        ST_RUN: begin
          Out[beat*SLICE +: SLICE] <= slice_res;
          if (beat == LAST_BEAT) begin
            // Beat holds here; the next accept clears it, so it never overflows.
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            ready <= 1'b1;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          beat  <= '0;
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
